// File: rtl/mem_requester.sv
// mem_requester
// Memory-side initiator for the 13-bit CPU. Arbitrates between instruction
// fetch and load/store requests, drives the main memory strobes, waits for
// mem_done (or a timeout) and returns data/completion to the granted source.
//
// Parameters:
//   TIMEOUT            WAIT cycles without mem_done before abort (1..255)
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   i_fetch_req/addr   fetch request (level) and instruction address
//   o_fetch_ready/data one-cycle completion pulse and fetched word
//   i_ls_req/we/addr/wdata  load/store request (level), store flag, address, data
//   o_ls_ready/rdata   one-cycle completion pulse and load data (0 for stores)
//   o_err, o_err_count timeout pulse (with ready) and saturating timeout count
//   o_mem_*            memory address, write data and write/read/instruction strobes
//   i_mem_rdata/done   memory read data and completion flag
module mem_requester #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_fetch_req,
    input  logic [12:0] i_fetch_addr,
    output logic        o_fetch_ready,
    output logic [12:0] o_fetch_data,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [12:0] i_ls_addr,
    input  logic [12:0] i_ls_wdata,
    output logic        o_ls_ready,
    output logic [12:0] o_ls_rdata,
    output logic        o_err,
    output logic [7:0]  o_err_count,
    output logic [12:0] o_mem_address,
    output logic [12:0] o_mem_wdata,
    input  logic [12:0] i_mem_rdata,
    output logic        o_mem_write,
    output logic        o_mem_read,
    output logic        o_mem_instruction,
    input  logic        i_mem_done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic        r_last_ls;   // 1: last grant went to load/store
    logic        r_is_ls;     // current transaction belongs to load/store
    logic        r_we;        // current transaction is a store
    logic [7:0]  r_cnt;

    logic        w_grant_ls;
    logic        w_expired;
    logic [12:0] w_resp_data;

    // On a conflict the source that did not win last time gets the grant.
    assign w_grant_ls  = i_ls_req & (~i_fetch_req | ~r_last_ls);
    assign w_expired   = (r_cnt == 8'(TIMEOUT - 1));
    // Stores and aborted transactions return zero.
    assign w_resp_data = (i_mem_done && !r_we) ? i_mem_rdata : 13'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_last_ls         <= 1'b0;
            r_is_ls           <= 1'b0;
            r_we              <= 1'b0;
            r_cnt             <= 8'd0;
            o_fetch_ready     <= 1'b0;
            o_fetch_data      <= 13'd0;
            o_ls_ready        <= 1'b0;
            o_ls_rdata        <= 13'd0;
            o_err             <= 1'b0;
            o_err_count       <= 8'd0;
            o_mem_address     <= 13'd0;
            o_mem_wdata       <= 13'd0;
            o_mem_write       <= 1'b0;
            o_mem_read        <= 1'b0;
            o_mem_instruction <= 1'b0;
        end else begin
            // Ready/err are single-cycle pulses; they are raised only on
            // the WAIT->RESP transition below.
            o_fetch_ready <= 1'b0;
            o_ls_ready    <= 1'b0;
            o_err         <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_fetch_req || i_ls_req) begin
                        r_state   <= S_WAIT;
                        r_cnt     <= 8'd0;
                        r_is_ls   <= w_grant_ls;
                        r_last_ls <= w_grant_ls;
                        if (w_grant_ls) begin
                            o_mem_address     <= i_ls_addr;
                            o_mem_wdata       <= i_ls_we ? i_ls_wdata : 13'd0;
                            r_we              <= i_ls_we;
                            o_mem_write       <= i_ls_we;
                            o_mem_read        <= ~i_ls_we;
                            o_mem_instruction <= 1'b0;
                        end else begin
                            o_mem_address     <= i_fetch_addr;
                            o_mem_wdata       <= 13'd0;
                            r_we              <= 1'b0;
                            o_mem_write       <= 1'b0;
                            o_mem_read        <= 1'b1;
                            o_mem_instruction <= 1'b1;
                        end
                    end
                end

                S_WAIT: begin
                    if (i_mem_done || w_expired) begin
                        r_state           <= S_RESP;
                        o_mem_write       <= 1'b0;
                        o_mem_read        <= 1'b0;
                        o_mem_instruction <= 1'b0;
                        if (r_is_ls) begin
                            o_ls_ready <= 1'b1;
                            o_ls_rdata <= w_resp_data;
                        end else begin
                            o_fetch_ready <= 1'b1;
                            o_fetch_data  <= w_resp_data;
                        end
                        if (!i_mem_done) begin
                            o_err <= 1'b1;
                            if (o_err_count != 8'hFF)
                                o_err_count <= o_err_count + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_RESP: r_state <= S_IDLE;

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
module tb_mem_requester;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [12:0] fetch_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic        fetch_ready, ls_ready, err;
    logic [12:0] fetch_data, ls_rdata;
    logic [7:0]  err_count;
    logic [12:0] mem_address, mem_wdata;
    logic [12:0] mem_rdata = '0;
    logic        mem_write, mem_read, mem_instruction;
    logic        mem_done = 1'b0;

    always #5 clk = ~clk;

    mem_requester #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
        .o_fetch_ready(fetch_ready), .o_fetch_data(fetch_data),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .o_ls_ready(ls_ready), .o_ls_rdata(ls_rdata),
        .o_err(err), .o_err_count(err_count),
        .o_mem_address(mem_address), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_mem_write(mem_write), .o_mem_read(mem_read), .o_mem_instruction(mem_instruction),
        .i_mem_done(mem_done)
    );

    int n_cmp = 0, n_bad = 0;

    // Memory behaviour: raises done after done_delay strobe cycles.
    logic [12:0] mem     [0:8191];
    logic [12:0] ref_mem [0:8191];
    int done_delay = NEVER;
    int wcyc = 0;

    // Reference model state
    bit          m_last_ls = 1'b0;
    int          m_errs = 0;
    logic [12:0] m_fdata = '0, m_ldata = '0;

    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            mem_rdata = mem_write ? 13'($urandom) : mem[mem_address];
            if (wcyc == done_delay) begin
                mem_done = 1'b1;
                if (mem_write) mem[mem_address] = mem_wdata;
            end else begin
                mem_done = 1'b0;
            end
            wcyc++;
        end else begin
            mem_done  = 1'b0;
            wcyc      = 0;
            mem_rdata = 13'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue requests (from a negedge) and follow them to completion.
    task automatic run(input bit f_on, input bit l_on, input bit we,
                       input logic [12:0] fa, input logic [12:0] la, input logic [12:0] wd,
                       input int dly, input bit drop_early);
        bit          order [2];   // 1 = load/store
        int          ng, lat, seen, scyc;
        bit          abort, is_ls;
        logic [12:0] ed, a;
        logic [28:0] es;
        ng = 0; seen = 0; scyc = 0;
        if (f_on && l_on) begin
            order[0] = !m_last_ls; order[1] = m_last_ls; ng = 2;
        end else if (f_on) begin
            order[0] = 1'b0; ng = 1;
        end else begin
            order[0] = 1'b1; ng = 1;
        end
        m_last_ls = order[ng-1];
        abort = (dly >= TIMEOUT);
        lat   = abort ? TIMEOUT + 1 : dly + 2;
        done_delay = dly;
        fetch_req = f_on; fetch_addr = fa;
        ls_req = l_on; ls_we = we; ls_addr = la; ls_wdata = wd;
        for (int k = 1; k <= ng * (lat + 1) + 2; k++) begin
            @(negedge clk);
            if (k == 1 && drop_early && ng == 1) begin
                fetch_req = 1'b0; ls_req = 1'b0;
            end
            if ((mem_read || mem_write) && seen < ng) begin
                if (!order[seen])  es = {3'b011, fa, 13'd0};
                else if (we)       es = {3'b100, la, wd};
                else               es = {3'b010, la, 13'd0};
                chk("strobes", {mem_write, mem_read, mem_instruction, mem_address, mem_wdata}, es);
                scyc++;
            end
            chk("err_alone", err & ~(fetch_ready | ls_ready), 0);
            if (fetch_ready || ls_ready) begin
                if (seen >= ng) begin
                    chk("extra_ready", {fetch_ready, ls_ready}, 2'b00);
                end else begin
                    is_ls = order[seen];
                    a = is_ls ? la : fa;
                    chk("ready_src", {fetch_ready, ls_ready}, is_ls ? 2'b01 : 2'b10);
                    chk("ready_cycle", k, seen * (lat + 1) + lat);
                    ed = (abort || (is_ls && we)) ? 13'd0 : ref_mem[a];
                    if (!abort && is_ls && we) ref_mem[la] = wd;
                    if (abort && m_errs < 255) m_errs++;
                    if (is_ls) m_ldata = ed; else m_fdata = ed;
                    chk(is_ls ? "ls_rdata" : "fetch_data", is_ls ? ls_rdata : fetch_data, ed);
                    chk("err", err, abort);
                    chk("err_count", err_count, m_errs);
                    if (is_ls) ls_req = 1'b0; else fetch_req = 1'b0;
                    seen++;
                end
            end
        end
        chk("ready_count", seen, ng);
        chk("strobe_cycles", scyc, ng * (abort ? TIMEOUT : dly + 1));
        chk("fetch_hold", fetch_data, m_fdata);
        chk("ls_hold", ls_rdata, m_ldata);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fetch_req = 1'b0; ls_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {fetch_ready, fetch_data, ls_ready, ls_rdata, err, err_count,
             mem_address, mem_wdata, mem_write, mem_read, mem_instruction}, 0);
        reset = 1'b0;
        m_last_ls = 1'b0; m_errs = 0; m_fdata = '0; m_ldata = '0;
    endtask

    initial begin
        int mode, dly;
        bit drop;
        for (int i = 0; i < 8192; i++) begin
            mem[i] = '0; ref_mem[i] = '0;
        end
        mem[5] = 13'h0AB;  ref_mem[5] = 13'h0AB;
        mem[2] = 13'h1111; ref_mem[2] = 13'h1111;

        @(negedge clk);
        do_reset();

        // Directed: load, fetch, store, load-back
        run(0, 1, 0, 13'd0, 13'd5, 13'd0, 2, 0);
        run(1, 0, 0, 13'd2, 13'd0, 13'd0, 0, 0);
        chk("fetch_word", fetch_data, 13'b1000100010001);
        run(0, 1, 1, 13'd0, 13'd7, 13'h155, 1, 0);
        run(0, 1, 0, 13'd0, 13'd7, 13'd0, 0, 0);
        chk("store_readback", ls_rdata, 13'h155);

        // Arbitration from reset: ls, fetch, ls, fetch
        do_reset();
        run(1, 1, 0, 13'd2, 13'd5, 13'd0, 0, 0);
        run(1, 1, 0, 13'd2, 13'd5, 13'd0, 0, 0);

        // Timeout and err_count saturation
        run(0, 1, 0, 13'd0, 13'd5, 13'd0, NEVER, 0);
        chk("err_count_first", err_count, 8'd1);
        for (int i = 0; i < 299; i++)
            run(i[0], !i[0], 0, 13'd2, 13'd5, 13'd0, NEVER, 0);
        chk("err_count_sat", err_count, 8'd255);

        // Reset in the middle of WAIT of a load
        done_delay = NEVER;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 13'd5;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_strobes", {mem_write, mem_read, mem_instruction}, 3'b000);
        chk("rst_mid_errcnt", err_count, 8'd0);
        ls_req = 1'b0;
        reset = 1'b0;
        m_last_ls = 1'b0; m_errs = 0; m_fdata = '0; m_ldata = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_no_pulse", {fetch_ready, ls_ready, err}, 3'b000);
        end
        run(0, 1, 0, 13'd0, 13'd5, 13'd0, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 3);
            dly  = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
            drop = (mode != 3) && ($urandom_range(0, 1) == 1);
            run(mode == 0 || mode == 3, mode != 0,
                (mode == 2) || (mode == 3 && $urandom_range(0, 1) == 1),
                13'($urandom_range(0, 15)), 13'($urandom_range(0, 15)),
                13'($urandom), dly, drop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
